reaction_measure_fsm: RTL

Reaction-measurement controller for the FPGA reaction timer. It sits directly downstream of the delay counter. It arms and clears the delay counter, waits for the delay-expired indication, and lights the stimulus LED. It then counts elapsed milliseconds in BCD until the player presses the response button, and flags early presses and timeouts. It also holds the best time since reset for the display stage.

---
 rtl/reaction_measure_fsm.sv | 97 +++++++++
 1 files changed

// File: rtl/reaction_measure_fsm.sv
// reaction_measure_fsm: arms the delay counter, lights the stimulus LED and times the response in BCD ms,
// flagging early presses and timeouts and keeping the best valid time since reset.
module reaction_measure_fsm #(
  parameter logic [15:0] MAX_BCD = 16'h9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick_1ms,
  input  logic        start_pulse,
  input  logic        react_pulse,
  input  logic        delay_done,
  output logic        delay_clear,
  output logic        led,
  output logic [15:0] count_bcd,
  output logic [15:0] best_bcd,
  output logic        done,
  output logic        early,
  output logic        timeout
);
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_MEASURE, S_DONE, S_EARLY, S_TIMEOUT
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] w_count, w_count_inc;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic c;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) v[4*i +: 4] = 4'd0;
        else begin
          v[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return v;
  endfunction

  assign w_count_inc = bcd_inc(count_bcd);

  always_comb begin
    w_next  = r_state;
    w_count = count_bcd;
    case (r_state)
      S_IDLE:    w_next = start_pulse ? S_ARM : S_IDLE;
      S_ARM: begin
        w_next  = S_WAIT;
        w_count = 16'h0000;
      end
      S_WAIT:    w_next = react_pulse ? S_EARLY : (delay_done ? S_MEASURE : S_WAIT);
      S_MEASURE: begin
        // a response in the same cycle as a tick wins; the tick is dropped
        if (react_pulse) w_next = S_DONE;
        else if (tick_1ms) begin
          if (count_bcd == MAX_BCD) w_next = S_TIMEOUT;
          else w_count = w_count_inc;
        end
      end
      S_DONE:    w_next = start_pulse ? S_ARM : S_DONE;
      S_EARLY: begin
        w_next  = start_pulse ? S_ARM : S_EARLY;
        w_count = 16'h0000;
      end
      S_TIMEOUT: begin
        w_next  = start_pulse ? S_ARM : S_TIMEOUT;
        w_count = MAX_BCD;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      delay_clear <= 1'b1;
      led         <= 1'b0;
      count_bcd   <= 16'h0000;
      best_bcd    <= MAX_BCD;
      done        <= 1'b0;
      early       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      r_state     <= w_next;
      count_bcd   <= w_count;
      delay_clear <= w_next != S_WAIT;
      led         <= w_next == S_MEASURE;
      done        <= w_next == S_DONE && r_state != S_DONE;
      early       <= w_next == S_EARLY;
      timeout     <= w_next == S_TIMEOUT;
      // BCD digits order the same as binary, so a plain unsigned compare suffices
      if (r_state == S_MEASURE && w_next == S_DONE && count_bcd < best_bcd) best_bcd <= count_bcd;
    end
  end
endmodule
